voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphonic voice scheduler. Shares NUM_VOICES oscillator instances among a single stream of note-on/note-off commands (from the CPU register block or a sequencer).
- Per voice it drives the oscillator's increment, voice_select and rst inputs, and exports a gate to downstream envelope/mixer logic.
- Allocation order: retrigger a held key, else take the lowest free voice, else steal the oldest voice.

Parameters:
- NUM_VOICES, 4, number of oscillator voices managed (2..8)
- KEY_WIDTH, 7, width of the note/key identifier
- INC_WIDTH, 16, width of the phase increment per voice
- AGE_WIDTH, 4, width of the per-voice saturating age counter

Ports:
- sample_clock  in  1  sole clock; oscillators run on the same clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_note_on  in  1  1 = note-on, 0 = note-off
- cmd_key  in  KEY_WIDTH  key identifier
- cmd_increment  in  INC_WIDTH  phase increment for note-on
- cmd_waveform  in  4  oscillator voice_select value for note-on
- voice_increment  out  NUM_VOICES*INC_WIDTH  per-voice increment, voice i at [i*INC_WIDTH +: INC_WIDTH]
- voice_select  out  NUM_VOICES*4  per-voice waveform select
- voice_rst  out  NUM_VOICES  one-cycle phase-reset pulse per voice
- voice_gate  out  NUM_VOICES  voice currently held
- steal  out  1  one-cycle pulse when a held voice was stolen
- active_count  out  $clog2(NUM_VOICES+1)  number of gated voices

Behaviour:
- Reset (synchronous, active-high):
  - all voice_increment, voice_select, voice_gate, voice_key and age registers clear to 0.
  - voice_rst is all-ones while rst is high, so the oscillators are held in reset too.
  - steal = 0, active_count = 0, FSM = IDLE, cmd_ready = 0 while rst is high.
- FSM: IDLE -> LOOKUP -> COMMIT -> IDLE.
  - cmd_ready = (state == IDLE) && !rst.
  - A handshake (cmd_valid && cmd_ready at edge E0) latches the cmd_* fields and moves to LOOKUP.
- LOOKUP: at edge E1 the block registers:
  - match_hit/match_idx: lowest voice with gate = 1 and key == cmd_key.
  - free_hit/free_idx: lowest voice with gate = 0.
  - old_idx: gated voice with the maximum age; ties go to the lowest index.
- COMMIT: voice registers update at edge E2, then the FSM returns to IDLE.
  - cmd_ready is high again in the cycle after E2, so throughput is 1 command per 3 cycles.
  - Latency: outputs change 2 edges after acceptance.
- Note-on target selection: match_idx if hit, else free_idx if hit, else old_idx, which also pulses steal for the cycle after E2.
  - Target gets increment, waveform, key, gate = 1, age = 0; voice_rst[target] pulses for the cycle after E2.
  - Every other gated voice increments age, saturating at 2^AGE_WIDTH-1. Ungated ages hold at 0.
- Note-off:
  - If match_hit: gate = 0, voice_select = 0 (oscillator idles at midpoint), age = 0, increment unchanged, no voice_rst.
  - If no match: command is consumed with no state change and no pulses.
- active_count is a registered popcount of voice_gate and updates together with voice_gate.
- Boundary conditions:
  - Note-on for an already-held key never occupies a second voice.
  - Note-on with cmd_waveform = 0 is legal; the voice is gated but silent.
  - cmd_increment = 0 is legal.
  - cmd_* fields are ignored whenever no handshake occurs.
  - rst asserted during LOOKUP or COMMIT discards the command and produces no pulses.

Decomposition:
- Package audio_voice_pkg:
  - FSM state encoding (IDLE = 0, LOOKUP = 1, COMMIT = 2).
  - CMD_NOTE_OFF/CMD_NOTE_ON constants.
  - Waveform-select constants (SAW = 4'b0001, TRI = 4'b0010, SQUARE = 4'b0100, PULSE = 4'b1000).
- Sub-module voice_lookup: combinational search producing match/free/oldest indices from the packed gate/key/age vectors; voice_allocator registers its outputs in LOOKUP.

Test Plan:
- Reset, then note-on key 60 inc 0x0400 wf 0001 -> voice 0 gate = 1, increment 0x0400, select 0001, voice_rst[0] pulse, active_count 1, all 2 edges after accept.
- Note-ons for keys 60, 62, 64, 67, then note-on 69 -> voice 0 (age 3, oldest) stolen, steal = 1, voice 0 key 69, other voices unchanged, active_count stays 4.
- Note-on 60 twice with inc 0x0400 then 0x0800 -> same voice 0 retriggered with inc 0x0800, voice_rst[0] pulses twice, active_count 1.
- Note-on 60, 62; note-off 60; note-on 64 -> voice 0 gate drops with select 0; key 64 lands in voice 0 (lowest free); voice 1 age 2.
- Note-off key 72 with nothing held -> no output change, no pulses, cmd_ready returns high 3 cycles after accept.
- cmd_valid held high continuously with 10 commands -> exactly one accept per 3 cycles. rst pulsed during COMMIT of the 5th command -> all gates 0, command dropped, cmd_ready high the cycle after rst falls.

Source files
------------

// File: rtl/audio_voice_pkg.sv
// Shared encodings for the voice allocator: FSM states, command polarity
// and the oscillator waveform-select codes.
package audio_voice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic CMD_NOTE_OFF = 1'b0;
    localparam logic CMD_NOTE_ON  = 1'b1;

    localparam logic [3:0] WF_SAW    = 4'b0001;
    localparam logic [3:0] WF_TRI    = 4'b0010;
    localparam logic [3:0] WF_SQUARE = 4'b0100;
    localparam logic [3:0] WF_PULSE  = 4'b1000;

endpackage

// File: rtl/voice_lookup.sv
// Combinational voice search: held-key match, lowest free voice and the
// oldest gated voice (ties resolved toward the lowest index).
module voice_lookup #(
    parameter int NUM_VOICES = 4,
    parameter int KEY_WIDTH  = 7,
    parameter int AGE_WIDTH  = 4,
    localparam int IDX_W     = $clog2(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0]                i_gate,
    input  logic [NUM_VOICES-1:0][KEY_WIDTH-1:0] i_key,
    input  logic [NUM_VOICES-1:0][AGE_WIDTH-1:0] i_age,
    input  logic [KEY_WIDTH-1:0]                 i_cmd_key,
    output logic                                 o_match_hit,
    output logic [IDX_W-1:0]                     o_match_idx,
    output logic                                 o_free_hit,
    output logic [IDX_W-1:0]                     o_free_idx,
    output logic [IDX_W-1:0]                     o_old_idx
);

    logic                 w_old_found;
    logic [AGE_WIDTH-1:0] w_old_age;

    // Strict greater-than keeps the first (lowest) voice on equal ages.
    always_comb begin
        o_match_hit = 1'b0;
        o_match_idx = '0;
        o_free_hit  = 1'b0;
        o_free_idx  = '0;
        o_old_idx   = '0;
        w_old_found = 1'b0;
        w_old_age   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!o_match_hit && i_gate[i] && (i_key[i] == i_cmd_key)) begin
                o_match_hit = 1'b1;
                o_match_idx = IDX_W'(i);
            end
            if (!o_free_hit && !i_gate[i]) begin
                o_free_hit = 1'b1;
                o_free_idx = IDX_W'(i);
            end
            if (i_gate[i] && (!w_old_found || (i_age[i] > w_old_age))) begin
                w_old_found = 1'b1;
                w_old_age   = i_age[i];
                o_old_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: one note-on/note-off command per three cycles,
// retrigger held key, else lowest free voice, else steal the oldest voice.
module voice_allocator
    import audio_voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int KEY_WIDTH  = 7,
    parameter int INC_WIDTH  = 16,
    parameter int AGE_WIDTH  = 4
) (
    input  logic                              sample_clock,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_note_on,
    input  logic [KEY_WIDTH-1:0]              cmd_key,
    input  logic [INC_WIDTH-1:0]              cmd_increment,
    input  logic [3:0]                        cmd_waveform,
    output logic [NUM_VOICES*INC_WIDTH-1:0]   voice_increment,
    output logic [NUM_VOICES*4-1:0]           voice_select,
    output logic [NUM_VOICES-1:0]             voice_rst,
    output logic [NUM_VOICES-1:0]             voice_gate,
    output logic                              steal,
    output logic [$clog2(NUM_VOICES+1)-1:0]   active_count
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    state_t                               r_state;
    logic                                 r_cmd_note_on;
    logic [KEY_WIDTH-1:0]                 r_cmd_key;
    logic [INC_WIDTH-1:0]                 r_cmd_inc;
    logic [3:0]                           r_cmd_wf;

    logic                                 r_match_hit;
    logic [IDX_W-1:0]                     r_match_idx;
    logic                                 r_free_hit;
    logic [IDX_W-1:0]                     r_free_idx;
    logic [IDX_W-1:0]                     r_old_idx;

    logic [NUM_VOICES-1:0][INC_WIDTH-1:0] r_inc;
    logic [NUM_VOICES-1:0][3:0]           r_sel;
    logic [NUM_VOICES-1:0][KEY_WIDTH-1:0] r_key;
    logic [NUM_VOICES-1:0][AGE_WIDTH-1:0] r_age;
    logic [NUM_VOICES-1:0]                r_gate;
    logic [NUM_VOICES-1:0]                r_voice_rst;
    logic                                 r_steal;
    logic [CNT_W-1:0]                     r_active_count;

    logic                                 w_match_hit;
    logic [IDX_W-1:0]                     w_match_idx;
    logic                                 w_free_hit;
    logic [IDX_W-1:0]                     w_free_idx;
    logic [IDX_W-1:0]                     w_old_idx;

    logic [IDX_W-1:0]                     w_target;
    logic                                 w_commit_on;
    logic                                 w_commit_off;
    logic                                 w_is_steal;
    logic [NUM_VOICES-1:0]                w_gate_next;
    logic [CNT_W-1:0]                     w_count;

    voice_lookup #(
        .NUM_VOICES (NUM_VOICES),
        .KEY_WIDTH  (KEY_WIDTH),
        .AGE_WIDTH  (AGE_WIDTH)
    ) u_lookup (
        .i_gate      (r_gate),
        .i_key       (r_key),
        .i_age       (r_age),
        .i_cmd_key   (r_cmd_key),
        .o_match_hit (w_match_hit),
        .o_match_idx (w_match_idx),
        .o_free_hit  (w_free_hit),
        .o_free_idx  (w_free_idx),
        .o_old_idx   (w_old_idx)
    );

    assign cmd_ready       = (r_state == ST_IDLE) && !rst;
    assign voice_increment = r_inc;
    assign voice_select    = r_sel;
    assign voice_gate      = r_gate;
    assign voice_rst       = r_voice_rst | {NUM_VOICES{rst}};
    assign steal           = r_steal & ~rst;
    assign active_count    = r_active_count;

    // Commit decision and the post-commit gate vector, so the popcount
    // lands in the same edge as the gates it describes.
    always_comb begin
        w_target     = r_match_hit ? r_match_idx : (r_free_hit ? r_free_idx : r_old_idx);
        w_commit_on  = (r_state == ST_COMMIT) && (r_cmd_note_on == CMD_NOTE_ON);
        w_commit_off = (r_state == ST_COMMIT) && (r_cmd_note_on == CMD_NOTE_OFF) && r_match_hit;
        w_is_steal   = w_commit_on && !r_match_hit && !r_free_hit;
        w_gate_next  = r_gate;
        if (w_commit_on) begin
            w_gate_next[w_target] = 1'b1;
        end
        if (w_commit_off) begin
            w_gate_next[r_match_idx] = 1'b0;
        end
        w_count = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_count = w_count + CNT_W'(w_gate_next[i]);
        end
    end

    always_ff @(posedge sample_clock) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cmd_note_on  <= 1'b0;
            r_cmd_key      <= '0;
            r_cmd_inc      <= '0;
            r_cmd_wf       <= '0;
            r_match_hit    <= 1'b0;
            r_match_idx    <= '0;
            r_free_hit     <= 1'b0;
            r_free_idx     <= '0;
            r_old_idx      <= '0;
            r_inc          <= '0;
            r_sel          <= '0;
            r_key          <= '0;
            r_age          <= '0;
            r_gate         <= '0;
            r_voice_rst    <= '0;
            r_steal        <= 1'b0;
            r_active_count <= '0;
        end else begin
            r_voice_rst <= '0;
            r_steal     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_note_on <= cmd_note_on;
                        r_cmd_key     <= cmd_key;
                        r_cmd_inc     <= cmd_increment;
                        r_cmd_wf      <= cmd_waveform;
                        r_state       <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_match_hit <= w_match_hit;
                    r_match_idx <= w_match_idx;
                    r_free_hit  <= w_free_hit;
                    r_free_idx  <= w_free_idx;
                    r_old_idx   <= w_old_idx;
                    r_state     <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_state        <= ST_IDLE;
                    r_gate         <= w_gate_next;
                    r_active_count <= w_count;
                    r_steal        <= w_is_steal;
                    // Ages advance only when a command actually changes voice state.
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (w_commit_on && (IDX_W'(i) == w_target)) begin
                            r_inc[i]       <= r_cmd_inc;
                            r_sel[i]       <= r_cmd_wf;
                            r_key[i]       <= r_cmd_key;
                            r_age[i]       <= '0;
                            r_voice_rst[i] <= 1'b1;
                        end else if (w_commit_off && (IDX_W'(i) == r_match_idx)) begin
                            r_sel[i] <= '0;
                            r_age[i] <= '0;
                        end else if ((w_commit_on || w_commit_off) && r_gate[i] && (r_age[i] != '1)) begin
                            r_age[i] <= r_age[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: a table of directed commands with
// hand-computed voice state, plus throughput and mid-command reset sequences.
module tb_voice_allocator;
    import audio_voice_pkg::*;

    logic         sample_clock = 1'b0;
    logic         rst          = 1'b1;
    logic         cmd_valid    = 1'b0;
    logic         cmd_ready;
    logic         cmd_note_on  = 1'b0;
    logic [6:0]   cmd_key      = '0;
    logic [15:0]  cmd_increment = '0;
    logic [3:0]   cmd_waveform = '0;
    logic [63:0]  voice_increment;
    logic [15:0]  voice_select;
    logic [3:0]   voice_rst;
    logic [3:0]   voice_gate;
    logic         steal;
    logic [2:0]   active_count;

    int checkCount = 0;
    int errorCount = 0;

    voice_allocator #(
        .NUM_VOICES (4),
        .KEY_WIDTH  (7),
        .INC_WIDTH  (16),
        .AGE_WIDTH  (4)
    ) dut (
        .sample_clock    (sample_clock),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_note_on     (cmd_note_on),
        .cmd_key         (cmd_key),
        .cmd_increment   (cmd_increment),
        .cmd_waveform    (cmd_waveform),
        .voice_increment (voice_increment),
        .voice_select    (voice_select),
        .voice_rst       (voice_rst),
        .voice_gate      (voice_gate),
        .steal           (steal),
        .active_count    (active_count)
    );

    always #5 sample_clock = ~sample_clock;

    typedef struct {
        logic        doReset;
        logic        noteOn;
        logic [6:0]  key;
        logic [15:0] inc;
        logic [3:0]  wf;
        logic [3:0]  expGate;
        logic [3:0]  expRst;
        logic        expSteal;
        logic [2:0]  expCount;
        logic [63:0] expInc;
        logic [15:0] expSel;
    } vec_t;

    vec_t vecs[16];

    task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        @(negedge sample_clock);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge sample_clock);
        rst = 1'b0;
    endtask

    // Issues one command and returns at the negedge after the commit edge.
    task automatic sendCmd(input logic noteOn, input logic [6:0] key, input logic [15:0] inc, input logic [3:0] wf);
        int waitCycles = 0;
        #1;
        while (!cmd_ready && waitCycles < 20) begin
            @(negedge sample_clock);
            #1;
            waitCycles++;
        end
        if (!cmd_ready) begin
            checkValue("readyTimeout", {63'd0, cmd_ready}, 64'd1);
        end
        cmd_note_on   = noteOn;
        cmd_key       = key;
        cmd_increment = inc;
        cmd_waveform  = wf;
        cmd_valid     = 1'b1;
        @(negedge sample_clock);
        cmd_valid     = 1'b0;
        cmd_note_on   = 1'b1;
        cmd_key       = 7'h7F;
        cmd_increment = 16'hDEAD;
        cmd_waveform  = 4'hF;
        repeat (2) @(negedge sample_clock);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.doReset) applyReset();
        sendCmd(v.noteOn, v.key, v.inc, v.wf);
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        #1;
        checkValue($sformatf("v%0d.gate", idx), {60'd0, voice_gate}, {60'd0, v.expGate});
        checkValue($sformatf("v%0d.voiceRst", idx), {60'd0, voice_rst}, {60'd0, v.expRst});
        checkValue($sformatf("v%0d.steal", idx), {63'd0, steal}, {63'd0, v.expSteal});
        checkValue($sformatf("v%0d.count", idx), {61'd0, active_count}, {61'd0, v.expCount});
        checkValue($sformatf("v%0d.increment", idx), voice_increment, v.expInc);
        checkValue($sformatf("v%0d.select", idx), {48'd0, voice_select}, {48'd0, v.expSel});
        checkValue($sformatf("v%0d.ready", idx), {63'd0, cmd_ready}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int accepted;
        int lastAcc;

        vecs[0]  = '{1'b1, 1'b1, 7'd60, 16'h0400, WF_SAW,    4'b0001, 4'b0001, 1'b0, 3'd1, 64'h0000_0000_0000_0400, 16'h0001};
        vecs[1]  = '{1'b0, 1'b1, 7'd60, 16'h0800, WF_SAW,    4'b0001, 4'b0001, 1'b0, 3'd1, 64'h0000_0000_0000_0800, 16'h0001};
        vecs[2]  = '{1'b0, 1'b1, 7'd62, 16'h0500, WF_TRI,    4'b0011, 4'b0010, 1'b0, 3'd2, 64'h0000_0000_0500_0800, 16'h0021};
        vecs[3]  = '{1'b0, 1'b1, 7'd64, 16'h0600, WF_SQUARE, 4'b0111, 4'b0100, 1'b0, 3'd3, 64'h0000_0600_0500_0800, 16'h0421};
        vecs[4]  = '{1'b0, 1'b1, 7'd67, 16'h0700, WF_PULSE,  4'b1111, 4'b1000, 1'b0, 3'd4, 64'h0700_0600_0500_0800, 16'h8421};
        vecs[5]  = '{1'b0, 1'b1, 7'd69, 16'h0900, WF_SAW,    4'b1111, 4'b0001, 1'b1, 3'd4, 64'h0700_0600_0500_0900, 16'h8421};
        vecs[6]  = '{1'b0, 1'b0, 7'd62, 16'h1234, 4'hF,      4'b1101, 4'b0000, 1'b0, 3'd3, 64'h0700_0600_0500_0900, 16'h8401};
        vecs[7]  = '{1'b0, 1'b0, 7'd72, 16'h5555, 4'h3,      4'b1101, 4'b0000, 1'b0, 3'd3, 64'h0700_0600_0500_0900, 16'h8401};
        vecs[8]  = '{1'b0, 1'b1, 7'd64, 16'h0A00, WF_TRI,    4'b1101, 4'b0100, 1'b0, 3'd3, 64'h0700_0A00_0500_0900, 16'h8201};
        vecs[9]  = '{1'b0, 1'b1, 7'd65, 16'h0B00, 4'h0,      4'b1111, 4'b0010, 1'b0, 3'd4, 64'h0700_0A00_0B00_0900, 16'h8201};
        vecs[10] = '{1'b0, 1'b1, 7'd70, 16'h0000, WF_SQUARE, 4'b1111, 4'b1000, 1'b1, 3'd4, 64'h0000_0A00_0B00_0900, 16'h4201};
        vecs[11] = '{1'b1, 1'b0, 7'd60, 16'h0000, 4'h0,      4'b0000, 4'b0000, 1'b0, 3'd0, 64'h0000_0000_0000_0000, 16'h0000};
        vecs[12] = '{1'b0, 1'b1, 7'd60, 16'h0400, WF_SAW,    4'b0001, 4'b0001, 1'b0, 3'd1, 64'h0000_0000_0000_0400, 16'h0001};
        vecs[13] = '{1'b0, 1'b1, 7'd62, 16'h0500, WF_TRI,    4'b0011, 4'b0010, 1'b0, 3'd2, 64'h0000_0000_0500_0400, 16'h0021};
        vecs[14] = '{1'b0, 1'b0, 7'd60, 16'h0000, 4'h0,      4'b0010, 4'b0000, 1'b0, 3'd1, 64'h0000_0000_0500_0400, 16'h0020};
        vecs[15] = '{1'b0, 1'b1, 7'd64, 16'h0600, WF_SQUARE, 4'b0011, 4'b0001, 1'b0, 3'd2, 64'h0000_0000_0500_0600, 16'h0024};

        // Reset state while rst is still high.
        repeat (2) @(negedge sample_clock);
        #1;
        checkValue("rstVoiceRst", {60'd0, voice_rst}, 64'hF);
        checkValue("rstReady", {63'd0, cmd_ready}, 64'd0);
        checkValue("rstGate", {60'd0, voice_gate}, 64'd0);
        checkValue("rstCount", {61'd0, active_count}, 64'd0);
        checkValue("rstSteal", {63'd0, steal}, 64'd0);
        checkValue("rstIncrement", voice_increment, 64'd0);
        checkValue("rstSelect", {48'd0, voice_select}, 64'd0);

        // Note-off for an unheld key: consumed silently, ready back after three cycles.
        @(negedge sample_clock);
        rst          = 1'b0;
        cmd_note_on  = 1'b0;
        cmd_key      = 7'd72;
        cmd_valid    = 1'b1;
        #1;
        checkValue("offReadyIdle", {63'd0, cmd_ready}, 64'd1);
        @(negedge sample_clock);
        cmd_valid = 1'b0;
        #1;
        checkValue("offReadyLookup", {63'd0, cmd_ready}, 64'd0);
        @(negedge sample_clock);
        #1;
        checkValue("offReadyCommit", {63'd0, cmd_ready}, 64'd0);
        @(negedge sample_clock);
        #1;
        checkValue("offReadyAgain", {63'd0, cmd_ready}, 64'd1);
        checkValue("offGate", {60'd0, voice_gate}, 64'd0);
        checkValue("offVoiceRst", {60'd0, voice_rst}, 64'd0);
        checkValue("offSteal", {63'd0, steal}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        checkValue("ageVoice1", {60'd0, dut.r_age[1]}, 64'd2);
        checkValue("ageVoice0", {60'd0, dut.r_age[0]}, 64'd0);

        // Continuous valid: one accept every third cycle.
        applyReset();
        cmd_valid     = 1'b1;
        cmd_note_on   = 1'b1;
        cmd_key       = 7'd40;
        cmd_increment = 16'h0100;
        cmd_waveform  = WF_SAW;
        cyc = 0;
        accepted = 0;
        lastAcc = -1;
        while (accepted < 10 && cyc < 100) begin
            #1;
            if (cmd_ready) begin
                if (lastAcc >= 0) checkValue($sformatf("acceptGap%0d", accepted), 64'(cyc - lastAcc), 64'd3);
                lastAcc = cyc;
                accepted++;
                @(negedge sample_clock);
                cyc++;
                cmd_key = 7'(40 + accepted);
            end else begin
                @(negedge sample_clock);
                cyc++;
            end
        end
        cmd_valid = 1'b0;
        checkValue("acceptCount", 64'(accepted), 64'd10);
        repeat (3) @(negedge sample_clock);

        // Reset during the commit cycle of the fifth command drops it.
        applyReset();
        cmd_valid   = 1'b1;
        cmd_note_on = 1'b1;
        cmd_key     = 7'd40;
        cyc = 0;
        accepted = 0;
        while (accepted < 5 && cyc < 100) begin
            #1;
            if (cmd_ready) begin
                accepted++;
                @(negedge sample_clock);
                cyc++;
                cmd_key = 7'(40 + accepted);
            end else begin
                @(negedge sample_clock);
                cyc++;
            end
        end
        cmd_valid = 1'b0;
        checkValue("rstSeqAccepts", 64'(accepted), 64'd5);
        @(negedge sample_clock);
        #1;
        checkValue("gatesBeforeRst", {60'd0, voice_gate}, 64'hF);
        rst = 1'b1;
        #1;
        checkValue("midRstReady", {63'd0, cmd_ready}, 64'd0);
        checkValue("midRstVoiceRst", {60'd0, voice_rst}, 64'hF);
        @(negedge sample_clock);
        rst = 1'b0;
        #1;
        checkValue("postRstGate", {60'd0, voice_gate}, 64'd0);
        checkValue("postRstCount", {61'd0, active_count}, 64'd0);
        checkValue("postRstSteal", {63'd0, steal}, 64'd0);
        checkValue("postRstVoiceRst", {60'd0, voice_rst}, 64'd0);
        checkValue("postRstReady", {63'd0, cmd_ready}, 64'd1);
        @(negedge sample_clock);
        #1;
        checkValue("droppedGate", {60'd0, voice_gate}, 64'd0);
        checkValue("droppedVoiceRst", {60'd0, voice_rst}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
